sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_k_rom.sv | 11 +
 rtl/sha256_msg_schedule.sv | 113 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants and message-schedule sigma functions.
package sha256_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;
    typedef logic [5:0]   round_idx_t;

    typedef enum logic {IDLE, ROUND} state_e;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[addr].
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  addr,
    output logic [31:0] data
);

    assign data = K[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[t]/K[t] for 64 rounds from a 16-word circular buffer.
// Optional abort input enabled by defining SHA256_MSG_SCHED_ABORT_EN.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block_data,
`ifdef SHA256_MSG_SCHED_ABORT_EN
    input  logic         abort,
`endif
    output logic         round_valid,
    input  logic         round_ready,
    output logic [5:0]   round_idx,
    output logic [31:0]  w_data,
    output logic [31:0]  k_out,
    output logic         first_round,
    output logic         last_round
);

    state_e     state_q, state_d;
    round_idx_t t_q, t_d;
    word_t      buf_q [16];
    word_t      w_calc;
    logic       load;
    logic       advance;
    logic       abort_int;
    logic [3:0] slot, slot_m2, slot_m7, slot_m15;

`ifdef SHA256_MSG_SCHED_ABORT_EN
    assign abort_int = abort;
`else
    assign abort_int = 1'b0;
`endif

    // Slot t%16 still holds W[t-16] until this round's write replaces it.
    assign slot     = t_q[3:0];
    assign slot_m2  = slot - 4'd2;
    assign slot_m7  = slot - 4'd7;
    assign slot_m15 = slot - 4'd15;

    always_comb begin
        w_calc = buf_q[slot];
        if (t_q[5:4] != 2'b00) begin
            w_calc = sigma1(buf_q[slot_m2]) + buf_q[slot_m7]
                   + sigma0(buf_q[slot_m15]) + buf_q[slot];
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (block_valid && !abort_int) begin
                    state_d = ROUND;
                    t_d     = '0;
                    load    = 1'b1;
                end
            end
            ROUND: begin
                if (abort_int) begin
                    state_d = IDLE;
                    t_d     = '0;
                end else if (round_ready) begin
                    advance = 1'b1;
                    t_d     = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            if (load) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[i] <= block_data[511 - 32*i -: 32];
                end
            end else if (advance && (t_q[5:4] != 2'b00)) begin
                buf_q[slot] <= w_calc;
            end
        end
    end

    sha256_k_rom u_k_rom (
        .addr (t_q),
        .data (k_out)
    );

    assign block_ready = (state_q == IDLE);
    assign round_valid = (state_q == ROUND);
    assign round_idx   = t_q;
    assign w_data      = w_calc;
    assign first_round = round_valid && (t_q == 6'd0);
    assign last_round  = round_valid && (t_q == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a plain-array SHA-256 schedule model.
// Abort scenario compiled in when SHA256_MSG_SCHED_ABORT_EN is defined.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         round_valid;
    logic         round_ready;
    logic [5:0]   round_idx;
    logic [31:0]  w_data;
    logic [31:0]  k_out;
    logic         first_round;
    logic         last_round;
`ifdef SHA256_MSG_SCHED_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_msg_schedule dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
`ifdef SHA256_MSG_SCHED_ABORT_EN
        .abort       (abort),
`endif
        .round_valid (round_valid),
        .round_ready (round_ready),
        .round_idx   (round_idx),
        .w_data      (w_data),
        .k_out       (k_out),
        .first_round (first_round),
        .last_round  (last_round)
    );

    logic [31:0] kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] exp_w [64];

    logic [5:0]  obs_idx   [64];
    logic [31:0] obs_w     [64];
    logic [31:0] obs_k     [64];
    logic        obs_first [64];
    logic        obs_last  [64];
    int          obs_cyc   [64];
    int          obs_n;

    logic [5:0]  st_idx [8];
    logic [31:0] st_w   [8];
    logic [31:0] st_k   [8];
    int          st_n;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Full 64-word expansion over a flat array, textbook recurrence.
    function automatic void model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
        end
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // Handshakes a block in; returns on the negedge after the accepting edge.
    task automatic start_block(input logic [511:0] blk, output bit to);
        int cyc;
        to = 1'b0;
        @(negedge clk);
        block_valid = 1'b1;
        block_data  = blk;
        cyc = 0;
        while (!block_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!block_ready) begin
            to = 1'b1;
            block_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        block_valid = 1'b0;
    endtask

    // rmode 0: ready always high, 1: random ready. stall_at < 0 disables the stall.
    task automatic collect_block(input logic [511:0] blk, input int rmode,
                                 input int stall_at, input int stall_len, output bit to);
        int  cyc;
        int  stall_left;
        bit  stalled;
        obs_n = 0;
        st_n = 0;
        stall_left = 0;
        stalled = 1'b0;
        start_block(blk, to);
        if (to) return;
        cyc = 0;
        while (obs_n < 64 && cyc < 4000) begin
            if (!stalled && round_valid && int'(round_idx) == stall_at) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                round_ready = 1'b0;
                if (st_n < 8) begin
                    st_idx[st_n] = round_idx;
                    st_w[st_n]   = w_data;
                    st_k[st_n]   = k_out;
                    st_n++;
                end
                stall_left--;
            end else if (rmode == 1) begin
                round_ready = ($urandom_range(0, 3) != 0);
            end else begin
                round_ready = 1'b1;
            end
            if (round_valid && round_ready) begin
                obs_idx[obs_n]   = round_idx;
                obs_w[obs_n]     = w_data;
                obs_k[obs_n]     = k_out;
                obs_first[obs_n] = first_round;
                obs_last[obs_n]  = last_round;
                obs_cyc[obs_n]   = cyc;
                obs_n++;
            end
            @(negedge clk);
            cyc++;
        end
        round_ready = 1'b0;
        if (obs_n < 64) to = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (block_ready !== 1'b1) begin errors++;
            $display("FAIL rst_block_ready got %b want 1", block_ready); end
        checks++; if (round_valid !== 1'b0) begin errors++;
            $display("FAIL rst_round_valid got %b want 0", round_valid); end
        checks++; if ({first_round, last_round} !== 2'b00) begin errors++;
            $display("FAIL rst_markers got %b want 00", {first_round, last_round}); end
        checks++; if (round_idx !== 6'd0) begin errors++;
            $display("FAIL rst_round_idx got %0d want 0", round_idx); end
        checks++; if (w_data !== 32'h0) begin errors++;
            $display("FAIL rst_w_data got %h want 00000000", w_data); end
        checks++; if (k_out !== 32'h428a2f98) begin errors++;
            $display("FAIL rst_k_out got %h want 428a2f98", k_out); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_abc();
        logic [511:0] blk;
        bit to;
        blk = {32'h61626380, 448'h0, 32'h00000018};
        model(blk);
        collect_block(blk, 0, -1, 0, to);
        checks++; if (to) begin errors++;
            $display("FAIL abc_timeout got %0d rounds want 64", obs_n); end
        checks++; if (obs_w[0] !== 32'h61626380) begin errors++;
            $display("FAIL abc_w0 got %h want 61626380", obs_w[0]); end
        checks++; if (obs_w[15] !== 32'h00000018) begin errors++;
            $display("FAIL abc_w15 got %h want 00000018", obs_w[15]); end
        checks++; if (obs_w[16] !== 32'h61626380) begin errors++;
            $display("FAIL abc_w16 got %h want 61626380", obs_w[16]); end
        checks++; if (obs_w[17] !== 32'h000f0000) begin errors++;
            $display("FAIL abc_w17 got %h want 000f0000", obs_w[17]); end
        checks++; if (obs_k[0] !== 32'h428a2f98) begin errors++;
            $display("FAIL abc_k0 got %h want 428a2f98", obs_k[0]); end
        checks++; if (obs_k[63] !== 32'hc67178f2) begin errors++;
            $display("FAIL abc_k63 got %h want c67178f2", obs_k[63]); end
        checks++; if (obs_cyc[0] !== 0) begin errors++;
            $display("FAIL abc_latency got cycle %0d want 0", obs_cyc[0]); end
        checks++; if (obs_cyc[63] !== 63 || obs_last[63] !== 1'b1) begin errors++;
            $display("FAIL abc_last got cycle %0d last %b want 63 1", obs_cyc[63], obs_last[63]);
        end
        checks++; if (obs_first[0] !== 1'b1 || obs_last[0] !== 1'b0) begin errors++;
            $display("FAIL abc_first got %b%b want 10", obs_first[0], obs_last[0]); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_idx[t] !== 6'(t) || obs_w[t] !== exp_w[t] || obs_k[t] !== kt[t]) begin
                errors++;
                $display("FAIL abc_seq t=%0d got (%0d,%h,%h) want (%0d,%h,%h)", t,
                         obs_idx[t], obs_w[t], obs_k[t], t, exp_w[t], kt[t]);
            end
        end
        checks++; if (block_ready !== 1'b1 || round_valid !== 1'b0) begin errors++;
            $display("FAIL abc_return got ready %b valid %b want 1 0", block_ready, round_valid);
        end
    endtask

    task automatic test_stall();
        logic [511:0] blk;
        bit to;
        blk = rand_block();
        model(blk);
        collect_block(blk, 0, 20, 5, to);
        checks++; if (to || st_n != 5) begin errors++;
            $display("FAIL stall_run got rounds %0d stall %0d want 64 5", obs_n, st_n); end
        for (int i = 0; i < st_n; i++) begin
            checks++;
            if (st_idx[i] !== 6'd20 || st_w[i] !== exp_w[20] || st_k[i] !== kt[20]) begin
                errors++;
                $display("FAIL stall_hold i=%0d got (%0d,%h,%h) want (20,%h,%h)", i,
                         st_idx[i], st_w[i], st_k[i], exp_w[20], kt[20]);
            end
        end
        checks++; if (obs_cyc[20] !== 25) begin errors++;
            $display("FAIL stall_resume got cycle %0d want 25", obs_cyc[20]); end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_idx[t] !== 6'(t) || obs_w[t] !== exp_w[t] || obs_k[t] !== kt[t]) begin
                errors++;
                $display("FAIL stall_seq t=%0d got (%0d,%h,%h) want (%0d,%h,%h)", t,
                         obs_idx[t], obs_w[t], obs_k[t], t, exp_w[t], kt[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] b1, b2;
        bit to;
        int cyc;
        b1 = rand_block();
        b2 = rand_block();
        model(b2);
        round_ready = 1'b1;
        start_block(b1, to);
        block_valid = 1'b1;
        block_data  = b2;
        cyc = 0;
        while (!(round_valid && round_idx == 6'd63) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (!(round_valid && round_idx == 6'd63) || to) begin errors++;
            $display("FAIL b2b_reach63 got idx %0d valid %b want 63 1", round_idx, round_valid);
        end
        @(negedge clk);
        checks++; if (block_ready !== 1'b1 || round_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_idle got ready %b valid %b want 1 0", block_ready, round_valid);
        end
        @(negedge clk);
        block_valid = 1'b0;
        checks++;
        if (round_valid !== 1'b1 || round_idx !== 6'd0 || w_data !== exp_w[0]) begin
            errors++;
            $display("FAIL b2b_second got (%b,%0d,%h) want (1,0,%h)", round_valid, round_idx,
                     w_data, exp_w[0]);
        end
        cyc = 0;
        while (!block_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (block_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_drain got ready %b want 1", block_ready); end
        round_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [511:0] blk;
        bit to;
        for (int b = 0; b < 100; b++) begin
            blk = rand_block();
            model(blk);
            collect_block(blk, 1, -1, 0, to);
            checks++; if (to || obs_n != 64) begin errors++;
                $display("FAIL rnd_count blk=%0d got %0d want 64", b, obs_n); end
            for (int t = 0; t < obs_n; t++) begin
                checks++;
                if (obs_idx[t] !== 6'(t) || obs_w[t] !== exp_w[t] || obs_k[t] !== kt[t]
                    || obs_first[t] !== (t == 0) || obs_last[t] !== (t == 63)) begin
                    errors++;
                    $display("FAIL rnd_seq blk=%0d t=%0d got (%0d,%h,%h) want (%0d,%h,%h)", b, t,
                             obs_idx[t], obs_w[t], obs_k[t], t, exp_w[t], kt[t]);
                end
            end
            checks++; if (round_valid !== 1'b0) begin errors++;
                $display("FAIL rnd_extra blk=%0d got valid %b want 0", b, round_valid); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int cyc;
        round_ready = 1'b1;
        start_block(rand_block(), to);
        cyc = 0;
        while (!(round_valid && round_idx == 6'd37) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (!(round_valid && round_idx == 6'd37) || to) begin errors++;
            $display("FAIL rmid_reach37 got idx %0d want 37", round_idx); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (block_ready !== 1'b1 || round_valid !== 1'b0 || round_idx !== 6'd0
            || w_data !== 32'h0 || k_out !== 32'h428a2f98 || first_round !== 1'b0
            || last_round !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got (%b,%b,%0d,%h,%h) want (1,0,0,00000000,428a2f98)",
                     block_ready, round_valid, round_idx, w_data, k_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (block_ready !== 1'b1 || round_valid !== 1'b0) begin errors++;
                $display("FAIL rmid_release i=%0d got ready %b valid %b want 1 0", i,
                         block_ready, round_valid);
            end
        end
        round_ready = 1'b0;
    endtask

`ifdef SHA256_MSG_SCHED_ABORT_EN
    task automatic test_abort();
        logic [511:0] blk;
        bit to;
        int cyc;
        round_ready = 1'b1;
        start_block(rand_block(), to);
        cyc = 0;
        while (!(round_valid && round_idx == 6'd10) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        round_ready = 1'b0;
        checks++;
        if (round_valid !== 1'b0 || block_ready !== 1'b1 || round_idx !== 6'd0 || to) begin
            errors++;
            $display("FAIL abort_round got (%b,%b,%0d) want (0,1,0)", round_valid, block_ready,
                     round_idx);
        end
        block_valid = 1'b1;
        block_data  = rand_block();
        abort = 1'b1;
        @(negedge clk);
        block_valid = 1'b0;
        abort = 1'b0;
        checks++; if (round_valid !== 1'b0 || block_ready !== 1'b1) begin errors++;
            $display("FAIL abort_idle got valid %b ready %b want 0 1", round_valid, block_ready);
        end
        blk = rand_block();
        model(blk);
        collect_block(blk, 0, -1, 0, to);
        checks++; if (to || obs_idx[0] !== 6'd0 || obs_w[0] !== exp_w[0]) begin errors++;
            $display("FAIL abort_next got (%0d,%h) want (0,%h)", obs_idx[0], obs_w[0], exp_w[0]);
        end
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (obs_idx[t] !== 6'(t) || obs_w[t] !== exp_w[t] || obs_k[t] !== kt[t]) begin
                errors++;
                $display("FAIL abort_seq t=%0d got (%0d,%h,%h) want (%0d,%h,%h)", t,
                         obs_idx[t], obs_w[t], obs_k[t], t, exp_w[t], kt[t]);
            end
        end
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        block_valid = 1'b0;
        block_data  = '0;
        round_ready = 1'b0;
`ifdef SHA256_MSG_SCHED_ABORT_EN
        abort       = 1'b0;
`endif
        test_reset();
        test_abc();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SHA256_MSG_SCHED_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
